// File: rtl/top_audio_pkg.sv
// Shared types and helpers for the I2S test-tone transmitter.
// Optional build macro used by this slice: TOP_AUDIO_SAWTOOTH_EN.
package top_audio_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BITS  = 64;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;
  typedef logic        [31:0]            slot_t;

  // Sample left-justified in its 32-bit slot, low half zero-filled.
  function automatic slot_t mk_slot(input sample_t s);
    return {s, 16'h0000};
  endfunction

endpackage

// File: rtl/top_audio_if.sv
// I2S serial link between the external codec (master) and the transmitter (slave).
interface top_audio_if;
  logic LRCLK;
  logic I2S_Dout;

  modport master (output LRCLK, input I2S_Dout);
  modport slave  (input LRCLK, output I2S_Dout);
endinterface

// File: rtl/audio_tone_gen.sv
// Test-tone sample source, advanced once per frame on the SCLK falling edge.
// TOP_AUDIO_SAWTOOTH_EN selects a free-running sawtooth instead of the square wave.
module audio_tone_gen
  import top_audio_pkg::*;
#(
  parameter logic signed [15:0] AMPLITUDE        = 16'sh2000,
  parameter int                 TONE_HALF_FRAMES = 24
) (
  input  logic    SCLK,
  input  logic    AUDIO_EN,
  input  logic    frame_tick,
  output sample_t sample
);

  logic [7:0] cnt;

`ifdef TOP_AUDIO_SAWTOOTH_EN

  always_ff @(negedge SCLK or negedge AUDIO_EN) begin
    if (!AUDIO_EN) begin
      cnt <= 8'd0;
    end else if (frame_tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Offset-binary counter flipped to two's complement: 0 maps to full negative.
  assign sample = {cnt ^ 8'h80, 8'h00};

`else

  localparam logic [7:0] LAST_FRAME = 8'(TONE_HALF_FRAMES - 1);

  logic polarity;

  function automatic sample_t neg_sat(input sample_t a);
    if (a == sample_t'(16'h8000)) begin
      return sample_t'(16'h7FFF);
    end
    return -a;
  endfunction

  always_ff @(negedge SCLK or negedge AUDIO_EN) begin
    if (!AUDIO_EN) begin
      cnt      <= 8'd0;
      polarity <= 1'b0;
    end else if (frame_tick) begin
      if (cnt == LAST_FRAME) begin
        cnt      <= 8'd0;
        polarity <= ~polarity;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign sample = polarity ? neg_sat(AMPLITUDE) : AMPLITUDE;

`endif

endmodule

// File: rtl/top_audio_tx.sv
// I2S slave transmitter: LRCLK edge detection, frame shift register, tone source.
// TOP_AUDIO_SAWTOOTH_EN (see audio_tone_gen) swaps the square tone for a sawtooth.
module top_audio_tx
  import top_audio_pkg::*;
#(
  parameter logic signed [15:0] AMPLITUDE        = 16'sh2000,
  parameter int                 TONE_HALF_FRAMES = 24,
  parameter int                 SLOT_BITS        = 32
) (
  input  logic        SCLK,
  input  logic        AUDIO_EN,
  top_audio_if.slave  i2s
);

  logic                  lr_q;
  logic                  lr_prev;
  logic                  left_start;
  logic                  right_start;
  logic                  armed;
  logic [FRAME_BITS-1:0] AUDIO_Reg;
  slot_t                 r_hold;
  sample_t               sample;
  slot_t                 slot_now;

  audio_tone_gen #(
    .AMPLITUDE        (AMPLITUDE),
    .TONE_HALF_FRAMES (TONE_HALF_FRAMES)
  ) u_tone (
    .SCLK       (SCLK),
    .AUDIO_EN   (AUDIO_EN),
    .frame_tick (left_start),
    .sample     (sample)
  );

  assign slot_now = mk_slot(sample);

  // LRCLK sampled on the rising edge; start flags stay valid for exactly one falling edge.
  always_ff @(posedge SCLK or negedge AUDIO_EN) begin
    if (!AUDIO_EN) begin
      lr_q    <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      lr_q    <= i2s.LRCLK;
      lr_prev <= lr_q;
    end
  end

  assign left_start  = lr_prev & ~lr_q;
  assign right_start = ~lr_prev & lr_q;

  // Right slot is re-aligned from r_hold so both channels carry the frame's sample
  // even though the tone advances at the left edge.
  always_ff @(negedge SCLK or negedge AUDIO_EN) begin
    if (!AUDIO_EN) begin
      AUDIO_Reg <= '0;
      r_hold    <= '0;
      armed     <= 1'b0;
    end else if (left_start) begin
      AUDIO_Reg <= {slot_now, slot_now};
      r_hold    <= slot_now;
      armed     <= 1'b1;
    end else if (right_start && armed) begin
      AUDIO_Reg[FRAME_BITS-1 -: SLOT_BITS] <= r_hold;
    end else begin
      AUDIO_Reg <= {AUDIO_Reg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // The register MSB is the bit currently on the wire.
  assign i2s.I2S_Dout = AUDIO_Reg[FRAME_BITS-1];

endmodule

// File: tb/tb_top_audio_tx.sv
// Directed bench for top_audio_tx: reset, arming, framing, tone toggle, mid-slot reset.
module tb_top_audio_tx;
  import top_audio_pkg::*;

  logic SCLK     = 1'b0;
  logic AUDIO_EN = 1'b0;
  top_audio_if i2s();

  top_audio_tx dut (
    .SCLK     (SCLK),
    .AUDIO_EN (AUDIO_EN),
    .i2s      (i2s.slave)
  );

  always #5 SCLK = ~SCLK;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic bits[$];
  int   ls[1:27];
  int   rs[1:27];
  int   pre, m, x, a, b, t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One bit captured per SCLK period, mid-way between falling edges.
  task automatic tick();
    @(posedge SCLK);
    #1;
    bits.push_back(i2s.I2S_Dout);
  endtask

  task automatic half(input logic lr, input int n, output int start);
    @(negedge SCLK);
    i2s.LRCLK = lr;
    start = bits.size();
    repeat (n) tick();
  endtask

  function automatic logic [31:0] word_at(input int s);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = bits[s+1+i];
    return w;
  endfunction

  function automatic logic any_one(input int s, input int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r = r | bits[s+i];
    return r;
  endfunction

  function automatic logic [31:0] exp_slot(input int f);
`ifdef TOP_AUDIO_SAWTOOTH_EN
    logic [7:0] c;
    c = 8'(f - 1);
    return {c ^ 8'h80, 24'h000000};
`else
    return (((f - 1) / 24) % 2 == 1) ? 32'hE000_0000 : 32'h2000_0000;
`endif
  endfunction

  initial begin
    i2s.LRCLK = 1'b1;
    AUDIO_EN  = 1'b0;
    repeat (2) begin
      @(negedge SCLK);
      i2s.LRCLK = ~i2s.LRCLK;
    end
    @(posedge SCLK);
    #1;
    check("rst_dout",  64'(i2s.I2S_Dout), 64'h0);
    check("rst_reg",   dut.AUDIO_Reg,     64'h0);
    check("rst_cnt",   64'(dut.u_tone.cnt), 64'h0);
    check("rst_armed", 64'(dut.armed),    64'h0);
    #1 AUDIO_EN = 1'b1;

    // LRCLK high at release: the right edge seen first must be ignored.
    half(1'b1, 40, pre);
    check("prearm_quiet", 64'(any_one(pre, 40)), 64'h0);

    for (int f = 1; f <= 25; f++) begin
      half(1'b0, 32, ls[f]);
      half(1'b1, 32, rs[f]);
`ifndef TOP_AUDIO_SAWTOOTH_EN
      if (f == 24) begin
        check("f24_cnt_wrap", 64'(dut.u_tone.cnt),      64'h0);
        check("f24_polarity", 64'(dut.u_tone.polarity), 64'h1);
      end
`endif
    end

    // Short left half (truncated), long right half (zero tail).
    half(1'b0, 20, ls[26]);
    half(1'b1, 36, rs[26]);
    half(1'b0, 32, ls[27]);
    half(1'b1, 32, rs[27]);

    // Mid-slot reset during the next left half.
    @(negedge SCLK);
    i2s.LRCLK = 1'b0;
    m = bits.size();
    repeat (11) tick();
    #1 AUDIO_EN = 1'b0;
    #1;
    check("midrst_dout",  64'(i2s.I2S_Dout),     64'h0);
    check("midrst_reg",   dut.AUDIO_Reg,         64'h0);
    check("midrst_armed", 64'(dut.armed),        64'h0);
    check("midrst_cnt",   64'(dut.u_tone.cnt),   64'h0);
    repeat (5) tick();
    #1 AUDIO_EN = 1'b1;
    repeat (16) tick();
    check("midrst_quiet", 64'(any_one(m + 11, 21)), 64'h0);
    half(1'b1, 32, x);
    check("rearm_right_ignored", 64'(any_one(x, 32)), 64'h0);
    half(1'b0, 32, a);
    half(1'b1, 32, b);
    half(1'b0, 4, t);

    check("delay_bit", 64'(bits[ls[1]]), 64'h0);
    for (int f = 1; f <= 27; f++) begin
      if (f != 26) check($sformatf("left_f%0d", f), 64'(word_at(ls[f])), 64'(exp_slot(f)));
      check($sformatf("right_f%0d", f), 64'(word_at(rs[f])), 64'(exp_slot(f)));
    end
    check("long_right_tail", 64'(any_one(rs[26] + 33, 3)), 64'h0);
    check("restart_left",  64'(word_at(a)), 64'(exp_slot(1)));
    check("restart_right", 64'(word_at(b)), 64'(exp_slot(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/top_audio_tx.md
Name: top_audio_tx

Overview:
- I2S slave transmitter with a built-in test-tone source.
- Receives bit clock SCLK and word-select LRCLK from the external codec/master.
- Generates a 16-bit square-wave tone, identical on both channels, and serialises it MSB-first on I2S_Dout.
- Uses standard I2S framing: 32-bit slots, 64 SCLK per frame, one-SCLK MSB delay after each LRCLK edge.
- Used as the audio output stage and as a codec bring-up block.

Parameters:
- AMPLITUDE, 16'h2000: square-wave magnitude; two's complement, must be positive.
- TONE_HALF_FRAMES, 24: frames per half tone period (48 kHz fs gives 1 kHz).
- SLOT_BITS, 32: bits per channel slot; the sample is left-justified and the rest zero-filled.

Ports:
- SCLK  in  1  I2S bit clock; the only clock.
- AUDIO_EN  in  1  asynchronous active-low reset/enable; low holds the block in reset.
- LRCLK  in  1  word select; 0 = left, 1 = right; changes on SCLK falling edges.
- I2S_Dout  out  1  serial data, changes on SCLK falling edges.

Behaviour:
- Reset (AUDIO_EN=0, asynchronous), all state cleared:
  - AUDIO_Reg[63:0]=0, I2S_Dout=0, cnt[7:0]=0, polarity=0 (positive), lr_q=0, armed=0.
- LRCLK sampling:
  - On each SCLK rising edge: lr_q<=LRCLK; lr_prev<=lr_q.
  - left_start = lr_prev=1 && lr_q=0; right_start = lr_prev=0 && lr_q=1.
- Arming:
  - armed sets on the first left_start after reset.
  - Before that, right_start is ignored and I2S_Dout stays 0.
- Data driving, on each SCLK falling edge:
  - left_start pending: AUDIO_Reg <= {Lslot, Rslot}; I2S_Dout <= Lslot[31].
    - The MSB therefore appears in the first SCLK period after the LRCLK transition.
  - right_start pending and armed: AUDIO_Reg[63:32] <= Rslot (re-align); I2S_Dout <= Rslot[31].
  - Otherwise: AUDIO_Reg <= AUDIO_Reg<<1 (zero fill); I2S_Dout <= AUDIO_Reg[62].
  - Each start event is consumed exactly once.
- Slot format: slot = {sample[15:0], 16'h0000}.
- Sample value: +AMPLITUDE when polarity=0, -AMPLITUDE when polarity=1.
- Tone update, at each consumed left_start, after the frame is loaded:
  - cnt == TONE_HALF_FRAMES-1: cnt <= 0 and polarity toggles.
  - Otherwise cnt <= cnt+1.
- Boundary cases:
  - More than 32 SCLK per channel: extra bits are 0.
  - Fewer than 32 SCLK per channel: the slot is truncated and the next edge re-aligns.
  - AUDIO_EN low mid-frame: immediate clear; output resumes only after the next left_start.
  - Glitch-free LRCLK is required; a single-period pulse is treated as two edges.

Optional Feature:
- Macro: TOP_AUDIO_SAWTOOTH_EN.
- Defined:
  - Both channels carry a sawtooth: sample = {cnt^8'h80, 8'h00}.
  - cnt free-runs 0..255 and wraps; TONE_HALF_FRAMES and polarity are unused.
- Undefined: square wave as specified above.

Decomposition:
- Package top_audio_pkg:
  - Constants SAMPLE_BITS=16, FRAME_BITS=64.
  - typedef logic signed [15:0] sample_t; typedef logic [31:0] slot_t.
  - Function mk_slot(sample_t) returning slot_t.
- Sub-module audio_tone_gen (SCLK, AUDIO_EN, frame_tick in, sample out): owns cnt and polarity.
- top_audio_tx owns LRCLK edge detection and the shift register.

Test Plan:
- Hold AUDIO_EN=0 for 2 SCLK -> I2S_Dout=0, AUDIO_Reg=0, cnt=0; toggling LRCLK changes nothing.
- Release reset while LRCLK=1; first LRCLK fall -> the SCLK period after it carries Dout 0; next 32 bits are 0x20000000 MSB-first (bits 0,0,1,0 then 28 zeros).
- Same first frame, right half (LRCLK=1) -> bits again 0x20000000; no right data is emitted before the first left_start.
- Run 24 frames -> frame 25 carries 0xE0000000 on both slots; cnt returns to 0 at the toggle.
- Deassert AUDIO_EN mid-slot (bit 10) -> Dout=0 immediately; after re-enable, output restarts at the next LRCLK fall with +0x2000.
- TOP_AUDIO_SAWTOOTH_EN defined -> first frame slot 0x80000000, second 0x81000000; cnt wraps 255->0.
